spi_master_data_path: RTL and testbench

SPI_MASTER_DATA_PATH -- requirements
Module: spi_master_data_path

---
 rtl/spi_master_data_path_pkg.sv | 76 +++++++
 rtl/spi_master_data_path_sclk_gen.sv | 53 +++++
 rtl/spi_master_data_path.sv | 207 ++++++++++++++++++++
 tb/tb_spi_master_data_path.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_data_path_pkg.sv
// Shared definitions for the SPI master data path.
// Holds lane-mode encodings, frame field widths, status bit indices, the
// frame FSM state type and small helpers that turn a lane mode into lane
// width, lane mask and per-phase sclk cycle counts.
package spi_master_data_path_pkg;

  typedef enum logic [1:0] {
    MODE_ILLEGAL = 2'b00,
    MODE_X1      = 2'b01,
    MODE_X2      = 2'b10,
    MODE_X4      = 2'b11
  } spi_mode_e;

  localparam int ADDR_W       = 20;
  localparam int STAT_W       = 4;
  localparam int DATA_W       = 16;
  localparam int GAP_BITS     = 8;
  localparam int FRAME_W      = ADDR_W + STAT_W + GAP_BITS + DATA_W;
  // Wide enough for the longest single-word frame (49 sclk cycles at 1 lane).
  localparam int CNT_W        = 6;
  localparam int MIN_HALF_DIV = 4;

  localparam int STAT_WRITE = 2;
  localparam int STAT_BURST = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_ADDR,
    ST_STAT,
    ST_GAP,
    ST_DATA,
    ST_TAIL,
    ST_GUARD
  } state_e;

  // log2 of the lane count.
  function automatic int unsigned lane_shift(spi_mode_e m);
    case (m)
      MODE_X2: return 1;
      MODE_X4: return 2;
      default: return 0;
    endcase
  endfunction

  // Number of bits moved per sclk cycle.
  function automatic logic [2:0] lane_width(spi_mode_e m);
    case (m)
      MODE_X2: return 3'd2;
      MODE_X4: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(spi_mode_e m);
    case (m)
      MODE_X2: return 4'b0011;
      MODE_X4: return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  // Last value of the per-phase sclk cycle counter (cycles - 1).
  function automatic logic [CNT_W-1:0] phase_last(state_e s, spi_mode_e m);
    int unsigned sh;
    sh = lane_shift(m);
    case (s)
      ST_ADDR: return CNT_W'((ADDR_W >> sh) - 1);
      ST_STAT: return CNT_W'((STAT_W >> sh) - 1);
      ST_GAP:  return CNT_W'((GAP_BITS >> sh) - 1);
      ST_DATA: return CNT_W'((DATA_W >> sh) - 1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/spi_master_data_path_sclk_gen.sv
// sclk half-period divider.
// While i_en is high, sclk toggles every i_half clk cycles, starting low for
// one full half-period. o_rise/o_fall are single-cycle strobes asserted in
// the clk cycle just before sclk goes high/low, so logic acting on them
// updates on the same clk edge as sclk itself. i_gate forces the visible
// sclk low without disturbing the internal timing.
//   clk, reset_n : clock, async active-low reset
//   i_en         : run the divider (cleared -> counter and sclk return to 0)
//   i_gate       : allow sclk onto o_sclk
//   i_half       : half-period in clk cycles (already clamped by the caller)
//   o_sclk       : gated serial clock
//   o_rise/o_fall: edge strobes of the internal sclk
module spi_sclk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_gate,
  input  logic [DIV_W-1:0] i_half,
  output logic             o_sclk,
  output logic             o_rise,
  output logic             o_fall
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_tick;

  assign w_tick = i_en && (r_cnt == i_half - DIV_W'(1));

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
    end
  end

  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick &&  r_sclk;
  assign o_sclk = r_sclk && i_gate;

endmodule

// File: rtl/spi_master_data_path.sv
// SPI master frame data path.
// A frame is: LEAD half-period, ADDR (20 bits), STAT (4 bits), GAP (8 zero
// bits), DATA (16 bits), one TAIL sclk cycle, and optionally further
// DATA+TAIL words for bursts, then a GUARD of two half-periods with cs_n high.
// Bits leave LSB first on 1, 2 or 4 lanes; mosi changes with sclk rising
// and the slave samples on the falling edge; miso is sampled on falling edges.
//   clk, reset_n      : clock, async active-low reset
//   start             : launch request, honoured only in IDLE
//   spi_mode          : lane width (01/10/11), 00 rejected with err
//   half_div          : sclk half-period in clk cycles (min 4)
//   addr_i/status_i   : frame header; status_i[2]=write, [1]=burst
//   wdata_i           : write word, captured at start and per burst word
//   burst_more        : during TAIL of a burst, request another word
//   busy, wdata_req   : frame active / wdata_i captured pulse
//   rdata_o/rdata_valid: last read word and its update pulse
//   done, err         : frame finished / start rejected pulses
//   sclk, cs_n, mosi  : SPI outputs; miso: SPI input (2-flop synchronised)
module spi_master_data_path
  import spi_master_data_path_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        spi_mode,
  input  logic [DIV_W-1:0]  half_div,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [STAT_W-1:0] status_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              burst_more,
  output logic              busy,
  output logic              wdata_req,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic              sclk,
  output logic              cs_n,
  output logic [3:0]        mosi,
  input  logic [3:0]        miso
);

  state_e             r_state;
  state_e             w_next;
  spi_mode_e          r_mode;
  logic [DIV_W-1:0]   r_half;
  logic               r_write;
  logic               r_burst;
  logic [FRAME_W-1:0] r_sh;
  logic [FRAME_W-1:0] w_src;
  logic [3:0]         r_mosi;
  logic [CNT_W-1:0]   r_cyc;
  logic [DATA_W-1:0]  r_rx;
  logic [DATA_W-1:0]  r_rdata;
  logic [3:0]         r_miso_meta;
  logic [3:0]         r_miso_sync;
  logic               r_err;
  logic               r_wdata_req;
  logic               r_done;
  logic               r_rdata_valid;

  logic               w_rise;
  logic               w_fall;
  logic               w_gen_en;
  logic               w_sclk_gate;
  logic               w_start_ok;
  logic               w_start_bad;
  logic               w_last;
  logic               w_load_word;
  logic [DATA_W-1:0]  w_start_word;
  logic [DATA_W-1:0]  w_burst_word;

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_gen_en),
    .i_gate  (w_sclk_gate),
    .i_half  (r_half),
    .o_sclk  (sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_start_ok  = start && (r_state == ST_IDLE) && (spi_mode != MODE_ILLEGAL);
  assign w_start_bad = start && (r_state == ST_IDLE) && (spi_mode == MODE_ILLEGAL);
  assign w_last      = (r_cyc == '0);

  // Read frames shift zeros out during DATA.
  assign w_start_word = status_i[STAT_WRITE] ? wdata_i : '0;
  assign w_burst_word = r_write ? wdata_i : '0;

  // A burst continuation reloads the shifter on the same rise that starts
  // the next DATA word, so its first lane bits go out immediately.
  assign w_load_word = (r_state == ST_TAIL) && (w_next == ST_DATA);
  assign w_src       = w_load_word ? FRAME_W'(w_burst_word) : r_sh;

  // State register; async reset returns to IDLE so cs_n rises at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: every phase change happens on an sclk rise strobe.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok)         w_next = ST_LEAD;
      ST_LEAD:  if (w_rise)             w_next = ST_ADDR;
      ST_ADDR:  if (w_rise && w_last)   w_next = ST_STAT;
      ST_STAT:  if (w_rise && w_last)   w_next = ST_GAP;
      ST_GAP:   if (w_rise && w_last)   w_next = ST_DATA;
      ST_DATA:  if (w_rise && w_last)   w_next = ST_TAIL;
      ST_TAIL:  if (w_rise)             w_next = (r_burst && burst_more) ? ST_DATA : ST_GUARD;
      ST_GUARD: if (w_rise)             w_next = ST_IDLE;
      default:                          w_next = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy        = (r_state != ST_IDLE);
    cs_n        = (r_state == ST_IDLE) || (r_state == ST_GUARD);
    w_gen_en    = (r_state != ST_IDLE);
    // GUARD keeps the divider running to time its two half-periods, but
    // sclk must stay low on the wire.
    w_sclk_gate = !((r_state == ST_IDLE) || (r_state == ST_GUARD));
    mosi        = '0;
    if (r_state inside {ST_ADDR, ST_STAT, ST_GAP, ST_DATA, ST_TAIL}) mosi = r_mosi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_miso_meta <= '0;
      r_miso_sync <= '0;
    end else begin
      r_miso_meta <= miso;
      r_miso_sync <= r_miso_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode        <= MODE_X1;
      r_half        <= DIV_W'(MIN_HALF_DIV);
      r_write       <= 1'b0;
      r_burst       <= 1'b0;
      r_sh          <= '0;
      r_mosi        <= '0;
      r_cyc         <= '0;
      r_rx          <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_wdata_req   <= 1'b0;
      r_done        <= 1'b0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_err         <= w_start_bad;
      r_wdata_req   <= w_start_ok || w_load_word;
      r_done        <= (r_state == ST_GUARD) && (w_next == ST_IDLE);
      r_rdata_valid <= 1'b0;

      if (w_start_ok) begin
        r_mode  <= spi_mode_e'(spi_mode);
        r_half  <= (half_div < DIV_W'(MIN_HALF_DIV)) ? DIV_W'(MIN_HALF_DIV) : half_div;
        r_write <= status_i[STAT_WRITE];
        r_burst <= status_i[STAT_BURST];
        r_sh    <= {w_start_word, {GAP_BITS{1'b0}}, status_i, addr_i};
        r_mosi  <= '0;
      end else if (w_rise && (r_state != ST_GUARD)) begin
        // Once the header and word are consumed the shifter holds zeros,
        // which is exactly what TAIL drives.
        r_mosi <= w_src[3:0] & lane_mask(r_mode);
        r_sh   <= w_src >> lane_width(r_mode);
      end

      if (w_rise) begin
        if (w_next != r_state) r_cyc <= phase_last(w_next, r_mode);
        else                   r_cyc <= r_cyc - CNT_W'(1);
      end

      // Lanes enter at the top and move down, so the first-received lanes
      // end up at bits 0..w-1 after a full word.
      if (w_fall && !r_write) begin
        if (r_state == ST_DATA) begin
          case (r_mode)
            MODE_X2: r_rx <= {r_miso_sync[1:0], r_rx[DATA_W-1:2]};
            MODE_X4: r_rx <= {r_miso_sync,      r_rx[DATA_W-1:4]};
            default: r_rx <= {r_miso_sync[0],   r_rx[DATA_W-1:1]};
          endcase
        end else if (r_state == ST_TAIL) begin
          r_rdata       <= r_rx;
          r_rdata_valid <= 1'b1;
        end
      end
    end
  end

  assign err         = r_err;
  assign wdata_req   = r_wdata_req;
  assign done        = r_done;
  assign rdata_valid = r_rdata_valid;
  assign rdata_o     = r_rdata;

endmodule

// File: tb/tb_spi_master_data_path.sv
// Scoreboard bench for spi_master_data_path. Stimulus pushes expected
// events (read word, frame done, start rejected) into a queue; a monitor pops
// and compares them whenever the DUT pulses rdata_valid/done/err. A slave
// model on sclk captures mosi bits and drives miso read words.
module tb_spi_master_data_path;

  typedef enum int {EV_NONE, EV_RDATA, EV_DONE, EV_ERR} ev_e;
  typedef struct {
    ev_e         kind;
    logic [19:0] addr;
    logic [3:0]  stat;
    logic [15:0] data;
    logic        chk_data;
    int          cycles;
    int          half;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  spi_mode;
  logic [7:0]  half_div;
  logic [19:0] addr_i;
  logic [3:0]  status_i;
  logic [15:0] wdata_i;
  logic        burst_more;
  logic        busy, wdata_req, rdata_valid, done, err, sclk, cs_n;
  logic [15:0] rdata_o;
  logic [3:0]  mosi;
  logic [3:0]  slv_miso = 4'h0;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  // Slave model state.
  int           cur_w = 1;
  logic [15:0]  rd_words [4];
  int           rise_cnt = 0, last_rise = 0;
  logic [127:0] cap = '0, last_cap = '0;
  int           bitpos = 0;
  int           hi_cnt = 0, last_hi = 0;
  int           win_total = 0, win_prev = 0;

  spi_master_data_path #(.DIV_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .spi_mode    (spi_mode),
    .half_div    (half_div),
    .addr_i      (addr_i),
    .status_i    (status_i),
    .wdata_i     (wdata_i),
    .burst_more  (burst_more),
    .busy        (busy),
    .wdata_req   (wdata_req),
    .rdata_o     (rdata_o),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (slv_miso)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: count sclk cycles and drive miso for read data cycles. Header is
  // 32/w cycles, each word is 16/w data cycles plus one tail cycle.
  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      last_rise = rise_cnt;
      rise_cnt  = 0;
      slv_miso  = 4'h0;
    end else begin
      int hdr, len, off, j, k;
      logic [15:0] wd;
      rise_cnt++;
      hdr = 32 / cur_w;
      len = 16 / cur_w;
      slv_miso = 4'h0;
      if (rise_cnt > hdr) begin
        off = rise_cnt - hdr - 1;
        j   = off / (len + 1);
        k   = off % (len + 1);
        if (k < len && j < 4) begin
          wd = rd_words[j];
          for (int b = 0; b < cur_w; b++) slv_miso[b] = wd[k * cur_w + b];
        end
      end
    end
  end

  // Slave: capture mosi lanes on sclk falling edges, LSB first.
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n) begin
      last_cap = cap;
      cap      = '0;
      bitpos   = 0;
    end else begin
      for (int b = 0; b < cur_w; b++)
        if (bitpos + b < 128) cap[bitpos + b] = mosi[b];
      bitpos += cur_w;
    end
  end

  // sclk high time in clk cycles.
  always @(posedge clk) begin
    if (sclk) hi_cnt++;
    else if (hi_cnt != 0) begin
      last_hi = hi_cnt;
      hi_cnt  = 0;
    end
  end

  always @(negedge cs_n) win_total++;

  task automatic take(input ev_e kind, output exp_t e);
    if (sb.size() == 0) e.kind = EV_NONE;
    else                e = sb.pop_front();
    check("event_kind", 32'(kind), 32'(e.kind));
  endtask

  // Monitor: compare every output event with the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset_n) begin
      win_prev = win_total;
    end else begin
      if (rdata_valid) begin
        take(EV_RDATA, e);
        if (e.kind == EV_RDATA) check("rdata", 32'(rdata_o), 32'(e.data));
      end
      if (done) begin
        take(EV_DONE, e);
        if (e.kind == EV_DONE) begin
          check("sclk_cycles", 32'(last_rise), 32'(e.cycles));
          check("slave_addr", 32'(last_cap[19:0]), 32'(e.addr));
          check("slave_stat", 32'(last_cap[23:20]), 32'(e.stat));
          if (e.chk_data) check("slave_wdata", 32'(last_cap[47:32]), 32'(e.data));
          check("half_period", 32'(last_hi), 32'(e.half));
          check("cs_windows", 32'(win_total - win_prev), 32'd1);
        end
        win_prev = win_total;
      end
      if (err) begin
        take(EV_ERR, e);
        check("err_busy", 32'(busy), 32'd0);
        check("err_cs_n", 32'(cs_n), 32'd1);
      end
    end
  end

  task automatic push_rdata(input logic [15:0] d);
    exp_t e;
    e.kind = EV_RDATA; e.data = d; e.addr = '0; e.stat = '0;
    e.chk_data = 1'b0; e.cycles = 0; e.half = 0;
    sb.push_back(e);
  endtask

  task automatic push_done(input logic [19:0] a, input logic [3:0] s, input logic [15:0] d,
                           input logic chk, input int cyc, input int hp);
    exp_t e;
    e.kind = EV_DONE; e.addr = a; e.stat = s; e.data = d;
    e.chk_data = chk; e.cycles = cyc; e.half = hp;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.kind = EV_ERR; e.addr = '0; e.stat = '0; e.data = '0;
    e.chk_data = 1'b0; e.cycles = 0; e.half = 0;
    sb.push_back(e);
  endtask

  task automatic launch(input logic [1:0] m, input int hd, input logic [19:0] a,
                        input logic [3:0] s, input logic [15:0] wd);
    @(negedge clk);
    cur_w    = (m == 2'b11) ? 4 : (m == 2'b10) ? 2 : 1;
    spi_mode = m;
    half_div = 8'(hd);
    addr_i   = a;
    status_i = s;
    wdata_i  = wd;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && sb.size() > 0; i++) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; spi_mode = 2'b00; half_div = 8'd4;
    addr_i = '0; status_i = '0; wdata_i = '0; burst_more = 1'b0;
    for (int i = 0; i < 4; i++) rd_words[i] = '0;
    repeat (4) @(negedge clk);

    // Reset state.
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    check("rst_pulses", 32'({done, err, rdata_valid, wdata_req}), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1-lane write; a second start while busy must be ignored.
    push_done(20'hA5A5A, 4'h4, 16'h1234, 1'b1, 49, 4);
    launch(2'b01, 4, 20'hA5A5A, 4'h4, 16'h1234);
    check("t1_wdata_req", 32'(wdata_req), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cs_n", 32'(cs_n), 32'd0);
    repeat (40) @(negedge clk);
    spi_mode = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_busy_start", 32'(busy), 32'd1);
    wait_drain("t1_drain", 2000);

    // 4-lane read.
    rd_words[0] = 16'hBEEF;
    push_rdata(16'hBEEF);
    push_done(20'h00010, 4'h0, 16'h0000, 1'b0, 13, 4);
    launch(2'b11, 4, 20'h00010, 4'h0, 16'h0000);
    wait_drain("t2_drain", 1000);

    // 2-lane burst read of two words.
    rd_words[0] = 16'h1111;
    rd_words[1] = 16'h2222;
    burst_more  = 1'b1;
    push_rdata(16'h1111);
    push_rdata(16'h2222);
    push_done(20'h3C0F5, 4'h2, 16'h0000, 1'b0, 34, 6);
    launch(2'b10, 6, 20'h3C0F5, 4'h2, 16'hFFFF);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
        @(negedge clk);
        if (wdata_req) seen = 1'b1;
      end
      burst_more = 1'b0;
      check("t3_burst_wdata_req", 32'(seen), 32'd1);
    end
    wait_drain("t3_drain", 2000);
    check("t3_rdata_hold", 32'(rdata_o), 32'h2222);

    // Illegal mode.
    push_err();
    launch(2'b00, 4, 20'h11111, 4'h4, 16'h5555);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_cs_n", 32'(cs_n), 32'd1);
    repeat (5) @(negedge clk);
    check("t4_still_idle", 32'(busy), 32'd0);
    wait_drain("t4_drain", 50);

    // Reset during DATA, then a clean 4-lane write with half_div below min.
    launch(2'b01, 4, 20'h12345, 4'h4, 16'hCAFE);
    repeat (300) @(negedge clk);
    check("t5_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_cs_n", 32'(cs_n), 32'd1);
    check("t5_rst_sclk", 32'(sclk), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rdata", 32'(rdata_o), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    push_done(20'h54321, 4'h4, 16'h0F0F, 1'b1, 13, 4);
    launch(2'b11, 1, 20'h54321, 4'h4, 16'h0F0F);
    wait_drain("t5_drain", 1000);

    repeat (20) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
